// File: rtl/serial_twos_comp_if.sv
// Bundled handshake and data signals for serial_twos_comp.
// The master side drives the serial bits; the slave side is the converter.
interface serial_twos_comp_if #(parameter int CH = 4);
  logic          in_valid;
  logic          in_sof;
  logic [CH-1:0] i;
  logic [CH-1:0] neg;
  logic [CH-1:0] y;
  logic          out_valid;
  logic          out_sof;
  logic          out_eow;
  logic          busy;
  logic          err;
  logic [CH-1:0] ovf;

  modport master (
    output in_valid, in_sof, i, neg,
    input  y, out_valid, out_sof, out_eow, busy, err, ovf
  );
  modport slave (
    input  in_valid, in_sof, i, neg,
    output y, out_valid, out_sof, out_eow, busy, err, ovf
  );
endinterface

// File: rtl/serial_twos_comp.sv
// Multi-channel, word-framed serial two's-complement negator (LSB first).
// Define SCOMP_OVF_EN to generate the per-channel negation-overflow flag.
module serial_twos_comp_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic proc,
  input  logic sof,
`ifdef SCOMP_OVF_EN
  input  logic eow,
`endif
  input  logic i,
  input  logic neg,
  output logic y,
  output logic ovf
);
  logic neg_q, seen;
  logic neg_eff, seen_eff;

  // A sof bit starts a fresh word: use the new mode and forget earlier ones.
  assign neg_eff  = sof ? neg  : neg_q;
  assign seen_eff = sof ? 1'b0 : seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      seen  <= 1'b0;
      y     <= 1'b0;
    end else if (proc) begin
      y     <= (neg_eff & seen_eff) ? ~i : i;
      seen  <= seen_eff | i;
      neg_q <= neg_eff;
    end
  end

`ifdef SCOMP_OVF_EN
  // MSB is the only set bit of a negated word: the result wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else        ovf <= proc & eow & neg_q & i & ~seen;
  end
`else
  assign ovf = 1'b0;
`endif
endmodule

module serial_twos_comp #(
  parameter int CH     = 4,
  parameter int WORD_W = 8
) (
  input  logic t_clk,
  input  logic r,
  serial_twos_comp_if.slave bus
);
  localparam int CW = $clog2(WORD_W);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          valid_q, sof_q, eow_q, err_q;
  logic          beat, sof_beat, run_beat, proc, last, eow_beat, err_beat;
  logic [CH-1:0] y_w, ovf_w;

  assign beat     = bus.in_valid;
  assign sof_beat = beat & bus.in_sof;
  assign run_beat = beat & ~bus.in_sof & (state == RUN);
  assign proc     = sof_beat | run_beat;
  assign last     = (cnt == CW'(WORD_W - 1));
  assign eow_beat = run_beat & last;
  // Error: a bit outside a word, or a sof that aborts a word in flight.
  assign err_beat = beat & (bus.in_sof ? (state == RUN) : (state == IDLE));

  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eow_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= proc;
      sof_q   <= sof_beat;
      eow_q   <= eow_beat;
      err_q   <= err_beat;
      if (sof_beat) begin
        state <= RUN;
        cnt   <= CW'(1);
      end else if (run_beat) begin
        if (last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt   <= cnt + CW'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    serial_twos_comp_lane u_lane (
      .clk   (t_clk),
      .rst_n (r),
      .proc  (proc),
      .sof   (sof_beat),
`ifdef SCOMP_OVF_EN
      .eow   (eow_beat),
`endif
      .i     (bus.i[c]),
      .neg   (bus.neg[c]),
      .y     (y_w[c]),
      .ovf   (ovf_w[c])
    );
  end

  assign bus.y         = y_w;
  assign bus.ovf       = ovf_w;
  assign bus.out_valid = valid_q;
  assign bus.out_sof   = sof_q;
  assign bus.out_eow   = eow_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state == RUN);
endmodule

// File: tb/tb_serial_twos_comp.sv
// Randomised bench for serial_twos_comp against a word-value reference model.
// The expected bit k of each channel is bit k of (neg ? -value : value).
module tb_serial_twos_comp;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int VW = 2 * CH + 5;

  logic t_clk = 1'b0;
  logic r     = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_twos_comp_if #(.CH(CH)) bus ();
  serial_twos_comp #(.CH(CH), .WORD_W(W)) dut (.t_clk(t_clk), .r(r), .bus(bus));

  always #5 t_clk = ~t_clk;

  // reference model state
  bit            m_run;
  int            m_cnt;
  int unsigned   acc [CH];
  logic [CH-1:0] m_neg, e_y, e_ovf;
  logic          e_valid, e_sof, e_eow, e_err;

  function automatic logic [VW-1:0] act_vec();
    return {bus.y, bus.out_valid, bus.out_sof, bus.out_eow, bus.busy, bus.err, bus.ovf};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_y, e_valid, e_sof, e_eow, m_run, e_err, e_ovf};
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_cnt = 0; m_neg = '0; e_y = '0; e_ovf = '0;
    e_valid = 1'b0; e_sof = 1'b0; e_eow = 1'b0; e_err = 1'b0;
    for (int c = 0; c < CH; c++) acc[c] = 0;
  endtask

  // Drive one cycle, advance the model at the edge, return #1 after it.
  task automatic beat(input logic v, input logic s, input logic [CH-1:0] bits,
                      input logic [CH-1:0] nv);
    int k;
    bit p;
    int unsigned val;
    bus.in_valid = v; bus.in_sof = s; bus.i = bits; bus.neg = nv;
    @(posedge t_clk);
    e_valid = 1'b0; e_sof = 1'b0; e_eow = 1'b0; e_err = 1'b0; e_ovf = '0;
    p = 1'b0; k = 0;
    if (v) begin
      if (s) begin
        e_err = m_run; m_run = 1'b1; m_neg = nv; m_cnt = 1; e_sof = 1'b1; p = 1'b1;
        for (int c = 0; c < CH; c++) acc[c] = 0;
      end else if (!m_run) begin
        e_err = 1'b1;
      end else begin
        k = m_cnt; p = 1'b1;
        if (k == W - 1) begin
          e_eow = 1'b1; m_run = 1'b0; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    if (p) begin
      e_valid = 1'b1;
      for (int c = 0; c < CH; c++) begin
        acc[c] = acc[c] | (32'(bits[c]) << k);
        val = m_neg[c] ? (32'd0 - acc[c]) : acc[c];
        e_y[c] = val[k];
`ifdef SCOMP_OVF_EN
        if (e_eow && m_neg[c] && acc[c] == (32'd1 << (W - 1))) e_ovf[c] = 1'b1;
`endif
      end
    end
    #1;
  endtask

  function automatic logic [CH-1:0] col(input logic [CH-1:0][W-1:0] wd, input int b);
    logic [CH-1:0] o;
    for (int c = 0; c < CH; c++) o[c] = wd[c][b];
    return o;
  endfunction

  task automatic test_reset();
    logic [VW-1:0] a;
    model_reset();
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.i = '0; bus.neg = '0;
    repeat (2) @(posedge t_clk);
    #1;
    checks++;
    if (act_vec() !== '0) begin errors++; $display("FAIL reset_initial act=%h exp=0", act_vec()); end
    r = 1'b1;
    beat(1'b1, 1'b1, CH'($urandom), CH'($urandom));
    a = act_vec(); checks++;
    if (a !== exp_vec()) begin errors++; $display("FAIL reset_first_sof act=%h exp=%h", a, exp_vec()); end
    beat(1'b1, 1'b0, CH'($urandom), '0);
    beat(1'b1, 1'b0, CH'($urandom), '0);
    r = 1'b0;
    #1;
    checks++;
    if (act_vec() !== '0) begin errors++; $display("FAIL reset_async act=%h exp=0", act_vec()); end
    model_reset();
    @(posedge t_clk);
    #1 r = 1'b1;
    beat(1'b1, 1'b1, 4'b0001, 4'b0001);
    checks++;
    if (bus.out_sof !== 1'b1 || act_vec() !== exp_vec())
      begin errors++; $display("FAIL reset_release_sof act=%h exp=%h", act_vec(), exp_vec()); end
    for (int b = 1; b < W; b++) beat(1'b1, 1'b0, '0, '0);
  endtask

  task automatic test_negate();
    logic [CH-1:0][W-1:0] wd;
    logic [CH-1:0] nv;
    logic [W-1:0] g0, g1;
    for (int n = 0; n < 6; n++) begin
      for (int c = 0; c < CH; c++) wd[c] = W'($urandom);
      nv = CH'($urandom);
      if (n == 0) begin wd[0] = 8'h05; wd[1] = 8'h05; nv[0] = 1'b1; nv[1] = 1'b0; end
      for (int b = 0; b < W; b++) begin
        beat(1'b1, b == 0, col(wd, b), nv);
        g0[b] = bus.y[0]; g1[b] = bus.y[1];
        checks++;
        if (act_vec() !== exp_vec())
          begin errors++; $display("FAIL negate_bit w%0d b%0d act=%h exp=%h", n, b, act_vec(), exp_vec()); end
      end
      if (n == 0) begin
        checks++;
        if (g0 !== 8'hFB) begin errors++; $display("FAIL negate_ch0 act=%h exp=fb", g0); end
        checks++;
        if (g1 !== 8'h05) begin errors++; $display("FAIL pass_ch1 act=%h exp=05", g1); end
      end
    end
  endtask

  task automatic test_stall();
    logic [CH-1:0][W-1:0] wd;
    logic [CH-1:0] nv;
    int lows;
    for (int c = 0; c < CH; c++) wd[c] = W'($urandom);
    wd[0] = 8'h00;
    nv = CH'($urandom) | 4'b0001;
    lows = 0;
    for (int b = 0; b < W; b++) begin
      beat(1'b1, b == 0, col(wd, b), nv);
      checks++;
      if (act_vec() !== exp_vec())
        begin errors++; $display("FAIL stall_bit b%0d act=%h exp=%h", b, act_vec(), exp_vec()); end
      if (b == 3) begin
        for (int s = 0; s < 3; s++) begin
          beat(1'b0, 1'($urandom), CH'($urandom), CH'($urandom));
          if (!bus.out_valid) lows++;
          checks++;
          if (act_vec() !== exp_vec())
            begin errors++; $display("FAIL stall_hold s%0d act=%h exp=%h", s, act_vec(), exp_vec()); end
        end
      end
    end
    checks++;
    if (lows != 3) begin errors++; $display("FAIL stall_lows act=%0d exp=3", lows); end
  endtask

  task automatic test_framing();
    logic [CH-1:0][W-1:0] wd;
    logic [CH-1:0] nv;
    int eows;
    beat(1'b1, 1'b0, CH'($urandom), CH'($urandom));
    checks++;
    if (bus.err !== 1'b1 || act_vec() !== exp_vec())
      begin errors++; $display("FAIL idle_drop act=%h exp=%h", act_vec(), exp_vec()); end
    for (int c = 0; c < CH; c++) wd[c] = W'($urandom);
    nv = CH'($urandom);
    for (int b = 0; b < 5; b++) beat(1'b1, b == 0, col(wd, b), nv);
    for (int c = 0; c < CH; c++) wd[c] = W'($urandom);
    nv = CH'($urandom);
    eows = 0;
    for (int b = 0; b < W; b++) begin
      beat(1'b1, b == 0, col(wd, b), nv);
      if (bus.out_eow) eows++;
      checks++;
      if (act_vec() !== exp_vec())
        begin errors++; $display("FAIL abort_bit b%0d act=%h exp=%h", b, act_vec(), exp_vec()); end
    end
    checks++;
    if (eows != 1) begin errors++; $display("FAIL abort_eow_count act=%0d exp=1", eows); end
  endtask

  task automatic test_back_to_back();
    logic [CH-1:0][W-1:0] wd;
    logic [2*W-1:0] g0, eowm;
    int vcnt;
    vcnt = 0;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < CH; c++) wd[c] = W'($urandom);
      wd[0] = (n == 0) ? 8'h01 : 8'h7F;
      for (int b = 0; b < W; b++) begin
        beat(1'b1, b == 0, col(wd, b), 4'b0001);
        g0[n*W+b] = bus.y[0]; eowm[n*W+b] = bus.out_eow;
        if (bus.out_valid) vcnt++;
        checks++;
        if (act_vec() !== exp_vec())
          begin errors++; $display("FAIL b2b_bit w%0d b%0d act=%h exp=%h", n, b, act_vec(), exp_vec()); end
      end
    end
    checks++;
    if (g0 !== 16'h81FF) begin errors++; $display("FAIL b2b_data act=%h exp=81ff", g0); end
    checks++;
    if (vcnt != 16 || eowm !== 16'h8080)
      begin errors++; $display("FAIL b2b_frame valid=%0d eow=%h exp=16/8080", vcnt, eowm); end
  endtask

  task automatic test_overflow();
    logic [CH-1:0][W-1:0] wd;
    logic [CH-1:0] nv;
    logic xo;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < CH; c++) wd[c] = W'($urandom) & 8'h7F;
      wd[2] = (n == 0) ? 8'h80 : 8'h40;
      nv = CH'($urandom) | 4'b0100;
      for (int b = 0; b < W; b++) begin
        beat(1'b1, b == 0, col(wd, b), nv);
        checks++;
        if (act_vec() !== exp_vec())
          begin errors++; $display("FAIL ovf_bit w%0d b%0d act=%h exp=%h", n, b, act_vec(), exp_vec()); end
      end
`ifdef SCOMP_OVF_EN
      xo = (n == 0);
`else
      xo = 1'b0;
`endif
      checks++;
      if (bus.ovf[2] !== xo || bus.out_eow !== 1'b1)
        begin errors++; $display("FAIL ovf_flag w%0d act=%b exp=%b", n, bus.ovf[2], xo); end
    end
  endtask

  task automatic test_random();
    logic v, s;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) == 0) || (!m_run && $urandom_range(0, 1) == 1);
      beat(v, s, CH'($urandom), CH'($urandom));
      checks++;
      if (act_vec() !== exp_vec())
        begin errors++; $display("FAIL random_cycle n%0d act=%h exp=%h", n, act_vec(), exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_negate();
    test_stall();
    test_framing();
    test_back_to_back();
    test_overflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
